// File: rtl/dragonfang_floating_point_pkg.sv
// Shared floating-point constants, SEW encodings and the decoded execution-vector
// control word used by the Dragonfang vector execution stage.
package dragonfang_floating_point_pkg;

    localparam int FP32_EW   = 8;
    localparam int FP32_MW   = 23;
    localparam int FP32_BIAS = 127;
    localparam int FP64_EW   = 11;
    localparam int FP64_MW   = 52;
    localparam int FP64_BIAS = 1023;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

    localparam logic [2:0] SEW_32 = 3'b010;
    localparam logic [2:0] SEW_64 = 3'b011;

    typedef struct packed {
        logic       vfmul_en;
        logic [2:0] vsew;
    } execution_vector_t;

    localparam execution_vector_t vfmul_32 = '{vfmul_en: 1'b1, vsew: SEW_32};
    localparam execution_vector_t vfmul_64 = '{vfmul_en: 1'b1, vsew: SEW_64};

endpackage

// File: rtl/fp_multiplier.sv
// Combinational scalar IEEE multiplier, RNE only, flush-to-zero on inputs and on
// tiny results, canonical quiet NaN for every invalid or NaN case.
module fp_multiplier #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic [EW+MW:0] a_i,
    input  logic [EW+MW:0] b_i,
    output logic [EW+MW:0] p_o
);

    localparam int W  = 1 + EW + MW;
    localparam int PW = 2 * (MW + 1);
    localparam int XW = EW + 2;
    localparam logic [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
    localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic          sign;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [PW-1:0] prod;
    logic          top, guard, sticky, rup;
    logic [MW-1:0] frac;
    logic [MW:0]   frac_r;
    logic [XW-1:0] exp_s;

    assign sign   = a_i[W-1] ^ b_i[W-1];
    assign ea     = a_i[W-2 -: EW];
    assign eb     = b_i[W-2 -: EW];
    assign fa     = a_i[MW-1:0];
    assign fb     = b_i[MW-1:0];
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    // A zero exponent covers both true zero and subnormals (flushed on input).
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    assign prod   = {1'b1, fa} * {1'b1, fb};
    assign top    = prod[PW-1];
    assign frac   = top ? prod[PW-2 -: MW] : prod[PW-3 -: MW];
    assign guard  = top ? prod[MW] : prod[MW-1];
    assign sticky = top ? (|prod[MW-1:0]) : (|prod[MW-2:0]);
    assign rup    = guard & (sticky | frac[0]);
    assign frac_r = {1'b0, frac} + {{MW{1'b0}}, rup};
    // Exponent after normalization and rounding carry; signed in XW bits.
    assign exp_s  = {2'b00, ea} + {2'b00, eb} - BIAS
                  + {{(XW-1){1'b0}}, top} + {{(XW-1){1'b0}}, frac_r[MW]};

    always_comb begin
        p_o = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_o = QNAN;
        end else if (a_inf || b_inf) begin
            p_o = {sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero || b_zero) begin
            p_o = {sign, {(W-1){1'b0}}};
        end else if (!exp_s[XW-1] && (exp_s >= EMAX)) begin
            p_o = {sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (exp_s[XW-1] || (exp_s == '0)) begin
            p_o = {sign, {(W-1){1'b0}}};
        end else begin
            p_o = {sign, exp_s[EW-1:0], frac_r[MW-1:0]};
        end
    end

endmodule

// File: rtl/vector_fp_multiply_unit.sv
// vfmul.vv datapath: parallel binary32 and binary64 lanes, SEW select, one
// output register giving single-cycle latency.
module vector_fp_multiply_unit
    import dragonfang_floating_point_pkg::*;
#(
    parameter int VLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  execution_vector_t execution_vector,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN-1:0]   vs1,
    output logic [VLEN-1:0]   vd
);

    localparam int N64 = VLEN / 64;
    localparam int N32 = VLEN / 32;

    logic [VLEN-1:0] res32, res64;
    logic [VLEN-1:0] vd_d, vd_q;

    for (genvar i = 0; i < N64; i++) begin : g_e64
        fp_multiplier #(.EW(FP64_EW), .MW(FP64_MW)) u_mul (
            .a_i (vs2[i*64 +: 64]),
            .b_i (vs1[i*64 +: 64]),
            .p_o (res64[i*64 +: 64])
        );
    end

    for (genvar i = 0; i < N32; i++) begin : g_e32
        fp_multiplier #(.EW(FP32_EW), .MW(FP32_MW)) u_mul (
            .a_i (vs2[i*32 +: 32]),
            .b_i (vs1[i*32 +: 32]),
            .p_o (res32[i*32 +: 32])
        );
    end

    always_comb begin
        vd_d = '0;
        if (execution_vector.vfmul_en) begin
            case (execution_vector.vsew)
                SEW_32:  vd_d = res32;
                SEW_64:  vd_d = res64;
                default: vd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vd_q <= '0;
        else        vd_q <= vd_d;
    end

    assign vd = vd_q;

endmodule

// File: tb/tb_vector_fp_multiply_unit.sv
// Directed and model-checked bench for vector_fp_multiply_unit at VLEN = 64.
module tb_vector_fp_multiply_unit;
    import dragonfang_floating_point_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    execution_vector_t ev;
    logic [63:0]       vs2, vs1, vd;
    int                total = 0;
    int                bad = 0;

    localparam execution_vector_t EV_OFF = '{vfmul_en: 1'b0, vsew: SEW_64};
    localparam execution_vector_t EV_BAD = '{vfmul_en: 1'b1, vsew: 3'b000};

    vector_fp_multiply_unit #(.VLEN(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .execution_vector (ev),
        .vs2              (vs2),
        .vs1              (vs1),
        .vd               (vd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input execution_vector_t e,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        @(negedge clk);
        ev = e; vs2 = a; vs1 = b;
        @(posedge clk);
        #1;
        chk(tag, vd, exp);
    endtask

    function automatic logic [63:0] f32_to_dbl(input logic [31:0] f);
        logic [10:0] e;
        e = 11'(f[30:23]) - 11'd127 + 11'd1023;
        return {f[31], e, f[22:0], 29'b0};
    endfunction

    // Double-to-single RNE for values well inside the normal single range.
    function automatic logic [31:0] dbl_to_f32(input logic [63:0] d);
        logic [7:0]  e;
        logic [22:0] keep;
        logic [23:0] sum;
        logic        up;
        e    = 8'(d[62:52] - 11'd1023 + 11'd127);
        keep = d[51:29];
        up   = d[28] & ((|d[27:0]) | keep[0]);
        sum  = {1'b0, keep} + {23'b0, up};
        if (sum[23]) e = e + 8'd1;
        return {d[63], e, sum[22:0]};
    endfunction

    function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b);
        return dbl_to_f32($realtobits($bitstoreal(f32_to_dbl(a)) * $bitstoreal(f32_to_dbl(b))));
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] r;
        r[31]    = 1'($urandom);
        r[30:23] = 8'(107 + $urandom_range(0, 40));
        r[22:0]  = 23'($urandom);
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] r;
        r[63]    = 1'($urandom);
        r[62:52] = 11'(1003 + $urandom_range(0, 40));
        r[51:0]  = {20'($urandom), 32'($urandom)};
        return r;
    endfunction

    initial begin
        logic [63:0] a, b;
        ev = vfmul_64; vs2 = 64'h4000_0000_0000_0000; vs1 = 64'h4008_0000_0000_0000;
        #1;
        chk("reset_init", vd, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("e64_pre_reset", vfmul_64, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
            64'h4018_0000_0000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", vd, 64'h0);
        @(posedge clk);
        #1;
        chk("reset_held", vd, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run("e64_after_reset", vfmul_64, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
            64'h4018_0000_0000_0000);

        run("e32_two_lanes", vfmul_32, {32'h3FC00000, 32'h40000000},
            {32'h40000000, 32'hC0400000}, {32'h40400000, 32'hC0C00000});
        run("e32_rne_ovf", vfmul_32, {32'h3F800001, 32'h7F000000},
            {32'h3F800001, 32'h40000000}, {32'h3F800002, 32'h7F800000});
        run("e32_ftz_out", vfmul_32, {32'h00800000, 32'h3F800000},
            {32'h3F000000, 32'h3F800000}, {32'h00000000, 32'h3F800000});
        run("e32_inf_x_zero", vfmul_32, {32'h7F800000, 32'h00000000},
            {32'h00000000, 32'hFF800000}, {32'h7FC00000, 32'h7FC00000});
        run("e64_nan", vfmul_64, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
            64'h7FF8_0000_0000_0000);
        run("e64_zero_x_inf", vfmul_64, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
            64'h7FF8_0000_0000_0000);
        run("e32_neg_inf", vfmul_32, {32'hFF800000, 32'h7F800001},
            {32'h40000000, 32'h3F800000}, {32'hFF800000, 32'h7FC00000});
        run("e32_sub_zero", vfmul_32, {32'h00000001, 32'h80000000},
            {32'h7F000000, 32'h3F800000}, {32'h00000000, 32'h80000000});
        run("e64_ovf", vfmul_64, 64'hFFE0_0000_0000_0000, 64'h4000_0000_0000_0000,
            64'hFFF0_0000_0000_0000);

        run("en_off", EV_OFF, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h0);
        run("bad_sew", EV_BAD, {32'h3F800000, 32'h3F800000},
            {32'h3F800000, 32'h3F800000}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            run("en_off_rand", EV_OFF, {32'($urandom), 32'($urandom)},
                {32'($urandom), 32'($urandom)}, 64'h0);
        end

        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                a = rnd64(); b = rnd64();
                run("alt_e64", vfmul_64, a, b,
                    $realtobits($bitstoreal(a) * $bitstoreal(b)));
            end else begin
                a = {rnd32(), rnd32()}; b = {rnd32(), rnd32()};
                run("alt_e32", vfmul_32, a, b,
                    {ref32(a[63:32], b[63:32]), ref32(a[31:0], b[31:0])});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
